// File: rtl/mtf_cache_array.sv
// Move-to-front associative cache array. Cells are ordered MRU (cell 0) to
// LRU (cell CELL_CNT-1). A hit rotates the hit cell to the front; a miss
// optionally writes back a dirty LRU cell, optionally fills from memory, then
// inserts the new line at the front while the LRU cell falls off the end.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Once raised, valid and its payload stay unchanged until that
// edge. On the CPU side req_ready is the ready; on the memory side
// mem_req_ready is the ready. mem_rvalid is a one-cycle data strobe with no
// back-pressure and is only honoured while waiting for fill data.
module mtf_cache_array #(
  parameter int CELL_CNT = 4,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [2:0]        dbg_state
);

  localparam int IDX_W = $clog2(CELL_CNT);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOOKUP    = 3'd1;
  localparam logic [2:0] S_WB_REQ    = 3'd2;
  localparam logic [2:0] S_FILL_REQ  = 3'd3;
  localparam logic [2:0] S_FILL_WAIT = 3'd4;
  localparam logic [2:0] S_RESP      = 3'd5;

  logic [2:0]        state_q;
  logic [2:0]        state_d;

  logic [CELL_CNT-1:0] valid_q;
  logic [CELL_CNT-1:0] dirty_q;
  logic [ADDR_W-1:0]   tag_q  [CELL_CNT];
  logic [DATA_W-1:0]   data_q [CELL_CNT];

  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic [CELL_CNT-1:0] cmp;
  logic [CELL_CNT-1:0] enables;
  logic                hit;
  logic [IDX_W-1:0]    hit_idx;
  logic                lru_dirty;
  logic                do_hit;
  logic                do_insert;
  logic [DATA_W-1:0]   ins_data;

  assign dbg_state = state_q;

  // Per-cell tag compare against the latched request address.
  always_comb begin
    cmp = '0;
    for (int i = 0; i < CELL_CNT; i++) begin
      cmp[i] = valid_q[i] && (tag_q[i] == addr_q);
    end
  end

  // Priority enable: lowest matching index wins; every cell at or above it
  // (toward MRU) is enabled to shift down by one.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    enables = '0;
    for (int i = CELL_CNT - 1; i >= 0; i--) begin
      if (cmp[i]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
    for (int j = 0; j < CELL_CNT; j++) begin
      enables[j] = hit && (j <= int'(hit_idx));
    end
  end

  assign lru_dirty = valid_q[CELL_CNT-1] && dirty_q[CELL_CNT-1];
  assign do_hit    = (state_q == S_LOOKUP) && hit;
  // Insert happens directly from LOOKUP for a write with a clean LRU, after
  // the writeback handshake for a write, or when fill data arrives.
  assign do_insert = ((state_q == S_LOOKUP) && !hit && !lru_dirty && we_q) ||
                     ((state_q == S_WB_REQ) && mem_req_ready && we_q) ||
                     ((state_q == S_FILL_WAIT) && mem_rvalid);
  assign ins_data  = (state_q == S_FILL_WAIT) ? mem_rdata : wdata_q;

  // Next-state logic for the request sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) state_d = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (hit)            state_d = S_RESP;
        else if (lru_dirty) state_d = S_WB_REQ;
        else if (we_q)      state_d = S_RESP;
        else                state_d = S_FILL_REQ;
      end
      S_WB_REQ: begin
        if (mem_req_ready) state_d = we_q ? S_RESP : S_FILL_REQ;
      end
      S_FILL_REQ: begin
        if (mem_req_ready) state_d = S_FILL_WAIT;
      end
      S_FILL_WAIT: begin
        if (mem_rvalid) state_d = S_RESP;
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Capture the CPU request when it is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if ((state_q == S_IDLE) && req_valid) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Cell array: move-to-front on a hit, full shift-down on an insert.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
      for (int i = 0; i < CELL_CNT; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else if (do_hit) begin
      for (int j = 1; j < CELL_CNT; j++) begin
        if (enables[j]) begin
          valid_q[j] <= valid_q[j-1];
          dirty_q[j] <= dirty_q[j-1];
          tag_q[j]   <= tag_q[j-1];
          data_q[j]  <= data_q[j-1];
        end
      end
      valid_q[0] <= 1'b1;
      tag_q[0]   <= tag_q[hit_idx];
      data_q[0]  <= we_q ? wdata_q : data_q[hit_idx];
      dirty_q[0] <= dirty_q[hit_idx] | we_q;
    end else if (do_insert) begin
      for (int j = 1; j < CELL_CNT; j++) begin
        valid_q[j] <= valid_q[j-1];
        dirty_q[j] <= dirty_q[j-1];
        tag_q[j]   <= tag_q[j-1];
        data_q[j]  <= data_q[j-1];
      end
      valid_q[0] <= 1'b1;
      dirty_q[0] <= we_q;
      tag_q[0]   <= addr_q;
      data_q[0]  <= ins_data;
    end
  end

  // Outputs decoded from state; all zero in IDLE so reset forces them low
  // immediately. req_ready is additionally gated by rst_n.
  always_comb begin
    req_ready     = rst_n && (state_q == S_IDLE);
    resp_valid    = (state_q == S_RESP);
    resp_rdata    = (state_q == S_RESP) ? data_q[0] : '0;
    mem_req_valid = (state_q == S_WB_REQ) || (state_q == S_FILL_REQ);
    mem_we        = (state_q == S_WB_REQ);
    mem_addr      = '0;
    mem_wdata     = '0;
    if (state_q == S_WB_REQ) begin
      mem_addr  = tag_q[CELL_CNT-1];
      mem_wdata = data_q[CELL_CNT-1];
    end else if (state_q == S_FILL_REQ) begin
      mem_addr  = addr_q;
    end
  end

endmodule

// File: tb/tb_mtf_cache_array.sv
// Bench for mtf_cache_array: directed scenarios followed by random traffic,
// all checked against a queue-based move-to-front model and a memory model.
`timescale 1ns/1ps
module tb_mtf_cache_array;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 8;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mem_op_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          mem_req_valid;
  logic          mem_req_ready = 1'b0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic [2:0]    dbg_state;

  mtf_cache_array #(.CELL_CNT(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_vec = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [AW-1:0] m_tag[$];
  logic [DW-1:0] m_data[$];
  bit            m_dirty[$];
  logic [DW-1:0] mem_arr [logic [AW-1:0]];
  logic [DW-1:0] exp_q[$];
  mem_op_t       exp_mem_q[$];

  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  // Apply one CPU access to the model; fast=1 means no memory traffic.
  task automatic model_access(input bit we, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, output bit fast);
    int idx;
    logic [DW-1:0] dat;
    bit dty;
    idx = -1;
    fast = 1'b1;
    foreach (m_tag[i]) if (idx < 0 && m_tag[i] == a) idx = i;
    if (idx >= 0) begin
      dat = m_data[idx];
      dty = m_dirty[idx];
      m_tag.delete(idx);
      m_data.delete(idx);
      m_dirty.delete(idx);
      if (we) begin dat = d; dty = 1'b1; end
    end else begin
      if (m_tag.size() == N) begin
        if (m_dirty[N-1]) begin
          exp_mem_q.push_back('{1'b1, m_tag[N-1], m_data[N-1]});
          mem_arr[m_tag[N-1]] = m_data[N-1];
          fast = 1'b0;
        end
        void'(m_tag.pop_back());
        void'(m_data.pop_back());
        void'(m_dirty.pop_back());
      end
      if (we) dat = d;
      else begin
        dat = mem_val(a);
        exp_mem_q.push_back('{1'b0, a, '0});
        fast = 1'b0;
      end
      dty = we;
    end
    m_tag.push_front(a);
    m_data.push_front(dat);
    m_dirty.push_front(dty);
    exp_q.push_back(dat);
  endtask

  // ---------------- memory responder ----------------
  int            fill_dly = 1;
  int            hold_cnt = 0;
  int            junk_cnt = 0;
  int            rcnt = 0;
  bit            pend = 1'b0;
  bit            hs = 1'b0;
  logic [AW-1:0] haddr, paddr;

  initial begin
    forever begin
      @(negedge clk);
      hs    = rst_n && mem_req_valid && mem_req_ready && !mem_we;
      haddr = mem_addr;
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      if (!rst_n) begin
        pend = 1'b0;
        junk_cnt = 3;
      end else if (hs) begin
        pend  = 1'b1;
        rcnt  = (fill_dly != 0) ? fill_dly : $urandom_range(1, 4);
        paddr = haddr;
      end else if (pend) begin
        rcnt--;
        if (rcnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mem_val(paddr);
          pend       = 1'b0;
        end
      end else if (junk_cnt > 0 || $urandom_range(0, 4) == 0) begin
        if (junk_cnt > 0) junk_cnt--;
        mem_rvalid = 1'b1;
        mem_rdata  = 8'($urandom);
      end
      if (hold_cnt > 0) begin
        mem_req_ready = 1'b0;
        if (mem_req_valid) begin
          hold_cnt--;
          if (!pend && !mem_rvalid) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 8'hEE;
          end
        end
      end else begin
        mem_req_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // ---------------- scoreboard / compare process ----------------
  bit            prev_pend = 1'b0;
  mem_op_t       prev_op;
  bit            fill_out = 1'b0;
  bit            exp_resp_next = 1'b0;
  int            fill_cnt = 0;
  int            wb_cnt = 0;
  int            stall_cnt = 0;
  logic [AW-1:0] last_wb_addr = '0;
  logic [DW-1:0] last_wb_data = '0;
  logic [AW-1:0] last_fill_addr = '0;
  logic [DW-1:0] last_resp = '0;

  always @(negedge clk) begin
    mem_op_t e;
    if (!rst_n) begin
      prev_pend = 1'b0;
      fill_out = 1'b0;
      exp_resp_next = 1'b0;
    end else begin
      if (mem_req_valid && resp_valid) check("mem_resp_overlap", 1, 0);
      if (prev_pend) begin
        check("mem_hold_valid", mem_req_valid, 1);
        check("mem_hold_fields", {mem_we, mem_addr, mem_we ? mem_wdata : 8'h00},
              {prev_op.we, prev_op.addr, prev_op.we ? prev_op.wdata : 8'h00});
      end
      if (exp_resp_next) begin
        check("resp_after_fill", resp_valid, 1);
        exp_resp_next = 1'b0;
      end
      if (resp_valid) begin
        last_resp = resp_rdata;
        if (exp_q.size() == 0) check("resp_unexpected", 1, 0);
        else check("resp_rdata", resp_rdata, exp_q.pop_front());
      end
      if (mem_rvalid && fill_out) begin
        exp_resp_next = 1'b1;
        fill_out = 1'b0;
      end
      if (mem_req_valid && mem_req_ready) begin
        if (exp_mem_q.size() == 0) check("mem_unexpected", {mem_we, mem_addr}, 0);
        else begin
          e = exp_mem_q.pop_front();
          check("mem_we", mem_we, e.we);
          check("mem_addr", mem_addr, e.addr);
          if (e.we) begin
            check("mem_wdata", mem_wdata, e.wdata);
            wb_cnt++;
            last_wb_addr = mem_addr;
            last_wb_data = mem_wdata;
          end else begin
            fill_cnt++;
            last_fill_addr = mem_addr;
            fill_out = 1'b1;
          end
        end
      end
      if (mem_req_valid && !mem_req_ready) stall_cnt++;
      prev_pend = mem_req_valid && !mem_req_ready;
      prev_op   = '{mem_we, mem_addr, mem_wdata};
    end
  end

  // ---------------- driver ----------------
  // Call at posedge+1; returns at posedge+1 of the cycle after the response.
  task automatic do_req(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit fast;
    bit got;
    int cyc;
    int lat;
    model_access(we, a, d, fast);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    cyc = 0;
    while (!req_ready && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= 100) check("req_accept_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    got = 1'b0;
    while (!got && lat < 300) begin
      @(negedge clk);
      if (resp_valid) got = 1'b1;
      else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    if (!got) check("resp_timeout", 0, 1);
    if (fast) check("resp_latency", lat, 2);
    @(posedge clk); #1;
    check("ready_after_resp", req_ready, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_outs"}, {resp_valid, resp_rdata, mem_req_valid, mem_we, mem_addr, mem_wdata}, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit fast;
    int f0;
    int w0;
    int s0;
    int cyc;

    #2;
    check_reset_outputs("rst_init");
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    #1 check("ready_first_idle", req_ready, 1);
    @(posedge clk); #1;

    // Single read miss with a known memory word.
    mem_arr[16'h0010] = 8'hA5;
    fill_dly = 1;
    do_req(1'b0, 16'h0010, 8'h00);
    check("t1_fill_cnt", fill_cnt, 1);
    check("t1_fill_addr", last_fill_addr, 16'h0010);
    check("t1_resp", last_resp, 8'hA5);
    check("t1_model_cell0", {m_dirty[0], m_tag[0], m_data[0]}, {1'b0, 16'h0010, 8'hA5});
    fill_dly = 0;

    // Fill four lines, then a hit at index 2 reorders them.
    do_req(1'b0, 16'h0001, 8'h00);
    do_req(1'b0, 16'h0002, 8'h00);
    do_req(1'b0, 16'h0003, 8'h00);
    do_req(1'b0, 16'h0004, 8'h00);
    f0 = fill_cnt;
    do_req(1'b0, 16'h0002, 8'h00);
    check("t2_no_traffic", fill_cnt, f0);
    check("t2_order", {m_tag[0], m_tag[1], m_tag[2], m_tag[3]}, 64'h0002_0004_0003_0001);

    // Dirty a line by a write hit, then push it out to force a writeback.
    do_req(1'b1, 16'h0003, 8'h5A);
    check("t3_write_resp", last_resp, 8'h5A);
    do_req(1'b0, 16'h0005, 8'h00);
    do_req(1'b0, 16'h0006, 8'h00);
    do_req(1'b0, 16'h0007, 8'h00);
    check("t3_no_wb_yet", wb_cnt, 0);
    do_req(1'b0, 16'h0008, 8'h00);
    check("t3_wb_cnt", wb_cnt, 1);
    check("t3_wb_fields", {last_wb_addr, last_wb_data}, {16'h0003, 8'h5A});

    // Write miss with a clean LRU: no memory traffic, inserted dirty.
    f0 = fill_cnt;
    w0 = wb_cnt;
    do_req(1'b1, 16'h0020, 8'h11);
    check("t4_no_traffic", {fill_cnt, wb_cnt}, {f0, w0});
    check("t4_resp", last_resp, 8'h11);
    check("t4_model_dirty", m_dirty[0], 1);

    // Stalled fill request with stray fill strobes while stalled.
    s0 = stall_cnt;
    hold_cnt = 5;
    do_req(1'b0, 16'h0030, 8'h00);
    check("t5_stall_cycles", (stall_cnt - s0) >= 5, 1);

    // Reset while waiting for fill data.
    model_access(1'b0, 16'h0777, 8'h00, fast);
    fill_dly = 8;
    f0 = fill_cnt;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 16'h0777;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 0;
    while (fill_cnt == f0 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("t6_fill_issued", fill_cnt, f0 + 1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("t6_rst");
    m_tag.delete();
    m_data.delete();
    m_dirty.delete();
    exp_q.delete();
    exp_mem_q.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    repeat (5) @(posedge clk);
    #1;
    fill_dly = 0;
    do_req(1'b0, 16'h0777, 8'h00);
    check("t6_miss_after_rst", fill_cnt, f0 + 2);

    // Random traffic over a small address pool to mix hits and misses.
    for (int k = 0; k < 300; k++) begin
      do_req($urandom_range(0, 2) == 0, 16'h0100 + 16'($urandom_range(0, 11)), 8'($urandom));
    end

    repeat (4) @(posedge clk);
    check("end_exp_q_empty", exp_q.size(), 0);
    check("end_exp_mem_q_empty", exp_mem_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Watchdog against a hung run.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss + 1);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mtf_cache_array.md
# mtf_cache_array

Move-to-front associative cache array for the bf8b cache. It holds CELL_CNT single-word cells ordered MRU (cell 0) to LRU (cell CELL_CNT-1) and produces a per-cell tag-compare vector. It consumes the prio_enabler shift-enable mask to reorder cells on a hit, and sequences writeback and fill traffic to backing memory on a miss. It sits between the CPU data port and the memory bus.

## Interface
- CELL_CNT, 4, number of cells (≥2)
- ADDR_W, 16, address/tag width (full address is the tag, one word per cell)
- DATA_W, 8, data word width
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  CPU request valid
- req_ready  out  1  high only in IDLE
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  request address
- req_wdata  in  DATA_W  write data
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  DATA_W  read data (write data echoed on writes)
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_we  out  1  1 = writeback, 0 = fill read
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  writeback data
- mem_rvalid  in  1  fill data valid
- mem_rdata  in  DATA_W  fill data

## Operation
- Cell fields: valid, dirty, tag[ADDR_W], data[DATA_W]. Reset clears all fields.
- States: IDLE, LOOKUP, WB_REQ, FILL_REQ, FILL_WAIT, RESP.
- IDLE: on req_valid & req_ready, latch we/addr/wdata and go to LOOKUP.
- LOOKUP: cmp[i] = valid[i] & (tag[i] == latched addr). cmp feeds prio_enabler. Hit index h is the lowest i with cmp[i]=1.
  - Hit: for enables[j]=1 with j≥1, cell j <= cell j-1 (j ≤ h). Cell 0 <= hit entry. On a write, data <= wdata and dirty <= 1. Go to RESP.
  - Miss, cell CELL_CNT-1 valid & dirty: go to WB_REQ.
  - Miss, otherwise: a write goes straight to insert (no fill, whole-word write); a read goes to FILL_REQ.
- WB_REQ: mem_req_valid=1, mem_we=1, mem_addr=tag[CELL_CNT-1], mem_wdata=data[CELL_CNT-1]. Hold until mem_req_ready. On handshake, a write goes to insert and a read goes to FILL_REQ.
- FILL_REQ: mem_req_valid=1, mem_we=0, mem_addr=latched addr. Hold until mem_req_ready, then go to FILL_WAIT.
- FILL_WAIT: wait for mem_rvalid. mem_rvalid is ignored in every other state.
- Insert: all cells shift down one (mask all ones) and cell CELL_CNT-1 is dropped. Cell 0 <= {valid=1, tag=addr, data=mem_rdata or wdata, dirty=we}. Go to RESP.
- RESP: resp_valid=1, resp_rdata = cell 0 data. Return to IDLE.
- Tags are unique by construction; on duplicates, the lowest index wins.

## Timing
- Reset values: req_ready=0 while rst_n=0 and 1 in the first IDLE cycle after release; resp_valid=0, resp_rdata=0, mem_req_valid=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Assertion of rst_n mid-transaction drops mem_req_valid immediately and abandons the request. Any fill data arriving afterward is ignored.
- Request accepted at cycle T:
  - Hit: LOOKUP at T+1, resp_valid at T+2, req_ready at T+3.
  - Clean read miss: mem_req_valid from T+2. If mem_rvalid is seen in cycle F, the array updates at the F edge and resp_valid is at F+1.
  - Write miss, clean LRU: resp_valid at T+2; the insert happens on the LOOKUP edge.
- mem_req_valid and its address, we and wdata stay stable until the mem_req_ready handshake.
- mem_req_valid and resp_valid are never asserted together.
- Hit at h=0: no reorder; data/dirty update only.

## Test plan
- Reset, then read 0x0010 (memory returns 0xA5 two cycles after handshake): one fill with mem_addr=0x0010 and mem_we=0; resp_rdata=0xA5; cell0={1,0,0x0010,0xA5}.
- Fill addresses 0x1, 0x2, 0x3, 0x4, then read 0x2: hit with h=2, no memory traffic, resp at T+2. Order becomes 0x2, 0x4, 0x3, 0x1.
- Write 0x3 with 0x5A (hit), then fill 0x5, 0x6, 0x7, 0x8: when 0x3 reaches LRU and is evicted, one writeback with mem_addr=0x0003, mem_wdata=0x5A, mem_we=1, followed by the fill.
- Write miss to 0x0020 with 0x11, clean LRU: no mem request; resp_valid at T+2 with resp_rdata=0x11; cell0 dirty.
- Hold mem_req_ready=0 for 5 cycles in FILL_REQ: mem_req_valid and mem_addr stay stable; mem_rvalid pulsed during FILL_REQ is ignored.
- Assert rst_n low during FILL_WAIT: all outputs reach reset values asynchronously; a subsequent read of the same address misses.
